serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 142 ++++++++++++++
 tb/tb_serial_addsub.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// Optional signed saturation on overflow when SERIAL_ADDSUB_SAT_EN is defined.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, bx_sh;
  logic             carry, mode_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_next, final_res;
  logic             msb_cin, ovf_next, last_slice, accept;

  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
  end

  // Carry into the slice MSB is recovered from its sum bit, so overflow works for any DIGIT.
  always_comb begin
    slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, bx_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    msb_cin   = slice_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ bx_sh[DIGIT-1];
    ovf_next  = msb_cin ^ slice_sum[DIGIT];
  end

  // Earlier slices collect top-aligned; the final slice completes the word.
  generate
    if (DIGIT < WIDTH) begin : g_acc
      logic [WIDTH-DIGIT-1:0] acc;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             acc <= '0;
        else if (state == RUN)  acc <= acc_next[WIDTH-1:DIGIT];
      end
      assign acc_next = {slice_sum[DIGIT-1:0], acc};
    end else begin : g_no_acc
      assign acc_next = slice_sum[DIGIT-1:0];
    end
  endgenerate

`ifdef SERIAL_ADDSUB_SAT_EN
  logic a_msb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      a_msb <= 1'b0;
    else if (state == IDLE && accept) a_msb <= a[WIDTH-1];
  end
  always_comb begin
    final_res = acc_next;
    if (ovf_next) final_res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    final_res = acc_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      a_sh     <= '0;
      bx_sh    <= '0;
      carry    <= 1'b0;
      mode_q   <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            bx_sh  <= b ^ {WIDTH{mode}};
            carry  <= cin ^ mode;
            mode_q <= mode;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          bx_sh <= bx_sh >> DIGIT;
          carry <= slice_sum[DIGIT];
          cnt   <= last_slice ? '0 : cnt + CW'(1);
          if (last_slice) begin
            result   <= final_res;
            cout     <= slice_sum[DIGIT] ^ mode_q;
            overflow <= ovf_next;
            zero     <= (final_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 with DIGIT=1, 4 and 8 side by side.
// Expectations follow SERIAL_ADDSUB_SAT_EN when it is defined for the build.
module tb_serial_addsub;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
    logic [7:0] res_sat;
    logic       z_sat;
  } vec_t;

  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] in_ready, out_valid, cout, overflow, zero;
  logic [7:0] result [3];
  int         compared = 0, mismatched = 0;
  vec_t       vecs [9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_addsub #(.WIDTH(8), .DIGIT((g == 0) ? 1 : (g == 1) ? 4 : 8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[g]),
      .mode(mode), .a(a), .b(b), .cin(cin),
      .out_valid(out_valid[g]), .out_ready(out_ready), .result(result[g]),
      .cout(cout[g]), .overflow(overflow[g]), .zero(zero[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [7:0] exp_res(input vec_t v);
`ifdef SERIAL_ADDSUB_SAT_EN
    return v.res_sat;
`else
    return v.res;
`endif
  endfunction

  function automatic logic exp_zero(input vec_t v);
`ifdef SERIAL_ADDSUB_SAT_EN
    return v.z_sat;
`else
    return v.z;
`endif
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, idx, actual, expected);
    end
  endtask

  task automatic startOp(input vec_t v);
    for (int t = 0; t < 40 && in_ready !== 3'b111; t++) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("in_ready_idle", i, in_ready[i], 1);
    in_valid = 1'b1; mode = v.m; a = v.a; b = v.b; cin = v.ci;
    @(negedge clk);
    in_valid = 1'b0; mode = ~v.m; a = ~v.a; b = ~v.b; cin = ~v.ci;
    for (int i = 0; i < 3; i++) checkOutput("in_ready_busy", i, in_ready[i], 0);
  endtask

  task automatic waitDone(input vec_t v, input string tag);
    int lat [3] = '{0, 0, 0};
    for (int cyc = 1; cyc <= 20 && out_valid !== 3'b111; cyc++) begin
      for (int i = 0; i < 3; i++) if (out_valid[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (out_valid[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_latency"}, i, lat[i], lat_of(i));
      checkOutput({tag, "_result"}, i, result[i], exp_res(v));
      checkOutput({tag, "_cout"}, i, cout[i], v.co);
      checkOutput({tag, "_overflow"}, i, overflow[i], v.ov);
      checkOutput({tag, "_zero"}, i, zero[i], exp_zero(v));
    end
  endtask

  task automatic releaseOut();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("out_valid_after_release", i, out_valid[i], 0);
      checkOutput("in_ready_after_release", i, in_ready[i], 1);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    startOp(v);
    waitDone(v, tag);
    releaseOut();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    //          m   a      b      ci  res    co  ov  z   res_sat z_sat
    vecs[0] = '{0, 8'h05, 8'h03, 0, 8'h08, 0, 0, 0, 8'h08, 0};
    vecs[1] = '{1, 8'h03, 8'h05, 0, 8'hFE, 1, 0, 0, 8'hFE, 0};
    vecs[2] = '{0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 1, 8'h00, 1};
    vecs[3] = '{0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 0, 8'h7F, 0};
    vecs[4] = '{1, 8'h80, 8'h01, 0, 8'h7F, 0, 1, 0, 8'h80, 0};
    vecs[5] = '{0, 8'h10, 8'h20, 1, 8'h31, 0, 0, 0, 8'h31, 0};
    vecs[6] = '{1, 8'h05, 8'h05, 1, 8'hFF, 1, 0, 0, 8'hFF, 0};
    vecs[7] = '{1, 8'h05, 8'h05, 0, 8'h00, 0, 0, 1, 8'h00, 1};
    vecs[8] = '{0, 8'h80, 8'h80, 0, 8'h00, 1, 1, 1, 8'h80, 0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_in_ready", i, in_ready[i], 0);
      checkOutput("reset_out_valid", i, out_valid[i], 0);
      checkOutput("reset_result", i, result[i], 0);
      checkOutput("reset_flags", i, {cout[i], overflow[i], zero[i]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("in_ready_post_reset", i, in_ready[i], 1);

    for (int k = 0; k < 9; k++) applyStimulus(vecs[k], $sformatf("v%0d", k));

    // Backpressure: DONE held while inputs churn.
    startOp(vecs[0]);
    waitDone(vecs[0], "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid; a = 8'($urandom); b = 8'($urandom); mode = ~mode; cin = ~cin;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checkOutput("bp_result_hold", i, result[i], 8'h08);
        checkOutput("bp_flags_hold", i, {cout[i], overflow[i], zero[i]}, 0);
        checkOutput("bp_out_valid", i, out_valid[i], 1);
        checkOutput("bp_in_ready", i, in_ready[i], 0);
      end
    end
    in_valid = 1'b0;
    releaseOut();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("bp_no_extra_accept", i, out_valid[i], 0);

    // Reset abort in the third RUN cycle.
    v = '{0, 8'h10, 8'h20, 0, 8'h30, 0, 0, 0, 8'h30, 0};
    startOp(v);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort_in_ready", i, in_ready[i], 0);
      checkOutput("abort_out_valid", i, out_valid[i], 0);
      checkOutput("abort_result", i, result[i], 0);
      checkOutput("abort_flags", i, {cout[i], overflow[i], zero[i]}, 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 9) for (int i = 0; i < 3; i++) checkOutput("abort_no_result", i, out_valid[i], 0);
    end
    applyStimulus(v, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
